coffee_brew_arbiter: RTL

- Scheduler that shares one coffee brew/pour unit between N_REQ vending front-ends.
- Each front-end is a coin-handling FSM. It raises its req line once payment is complete and the drink is owed.
- The block grants the unit round-robin and checks that a cup is present. It then sequences heater, pour valve and clean phases, and reports completion or abort per requester.
- Sits between the coin-FSM instances and the brew actuators.

---
 rtl/coffee_brew_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/coffee_brew_arbiter.sv
// rtl/coffee_brew_arbiter.sv - round-robin arbiter sequencing one shared brew/pour unit
// Grants one front-end at a time, then walks cup check, heat, pour and rinse phases.
module coffee_brew_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BREW_CYCLES  = 8,
  parameter int POUR_CYCLES  = 4,
  parameter int CLEAN_CYCLES = 2,
  parameter int CUP_TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             cup_ok,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             heater_on,
  output logic             valve_open,
  output logic             done,
  output logic             done_ok,
  output logic [2:0]       done_id,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CUP_WAIT = 3'd1,
    S_BREW     = 3'd2,
    S_POUR     = 3'd3,
    S_CLEAN    = 3'd4
  } state_t;

  localparam int CW = 16;

  logic [2:0]       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [2:0]       r_ptr, w_ptr_nxt;
  logic             r_done, w_done_nxt;
  logic             r_done_ok, w_done_ok_nxt;
  logic [2:0]       r_done_id, w_done_id_nxt;
  logic [7:0]       w_req8;
  logic [2:0]       w_idx, w_win;
  logic             w_found;

  assign w_req8 = 8'(req);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
    w_done_nxt    = 1'b0;
    w_done_ok_nxt = 1'b0;
    w_done_id_nxt = 3'd0;
    w_found       = 1'b0;
    w_win         = 3'd0;
    w_idx         = 3'd0;

    // Scan starts just after the last served index so every requester gets a turn.
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = 3'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && w_req8[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_CUP_WAIT;
          w_gnt_nxt   = N_REQ'(1) << w_win;
          w_ptr_nxt   = w_win;
          w_cnt_nxt   = CW'(CUP_TIMEOUT - 1);
        end
      end
      S_CUP_WAIT: begin
        if (cup_ok) begin
          w_state_nxt = S_BREW;
          w_cnt_nxt   = CW'(BREW_CYCLES - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt   = S_CLEAN;
          w_gnt_nxt     = '0;
          w_done_nxt    = 1'b1;
          w_done_id_nxt = r_ptr;
          w_cnt_nxt     = CW'(CLEAN_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_BREW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_POUR;
          w_cnt_nxt   = CW'(POUR_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_POUR: begin
        // A missing cup stops the pour immediately rather than finishing the count.
        if (!cup_ok || r_cnt == '0) begin
          w_state_nxt   = S_CLEAN;
          w_gnt_nxt     = '0;
          w_done_nxt    = 1'b1;
          w_done_ok_nxt = cup_ok;
          w_done_id_nxt = r_ptr;
          w_cnt_nxt     = CW'(CLEAN_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_CLEAN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_ptr     <= 3'(N_REQ - 1);
      r_done    <= 1'b0;
      r_done_ok <= 1'b0;
      r_done_id <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_done    <= w_done_nxt;
      r_done_ok <= w_done_ok_nxt;
      r_done_id <= w_done_id_nxt;
    end
  end

  assign gnt        = r_gnt;
  assign busy       = (r_state != S_IDLE);
  assign heater_on  = (r_state == S_BREW);
  assign valve_open = (r_state == S_POUR);
  assign done       = r_done;
  assign done_ok    = r_done_ok;
  assign done_id    = r_done_id;
  assign state      = r_state;

endmodule
